// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues fixed-latency reads to instruction
// memory and presents each returned word to the control unit over valid/ready.
module fetch_unit #(
  parameter int                  PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic                mem_rd,
  input  logic [31:0]         mem_rdata,
  output logic [31:0]         instr,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [PC_WIDTH-1:0] pc,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted,
  output logic [31:0]         fetch_count,
  output logic [2:0]          state_dbg
);

  // Handshake: a transfer happens at a rising edge where instr_valid and
  // instr_ready are both high; instr/pc hold steady until then.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         count_q, count_d;
  logic [1:0]          lat_q, lat_d;
  logic                handshake;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    count_d   = count_q;
    lat_d     = lat_q;
    handshake = (state_q == S_HOLD) && instr_ready;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
        lat_d   = LAT_M1;
      end
      S_WAIT: begin
        if (lat_q == 2'd0) begin
          if (mem_rdata != 32'h0) begin
            instr_d = mem_rdata;
            state_d = S_HOLD;
          end else begin
            state_d = S_HALT;
          end
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_HOLD: begin
        if (handshake) begin
          pc_d    = pc_q + PC_WIDTH'(4);
          state_d = S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    if (handshake && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end

    // Redirect wins over the normal flow; any word arriving this cycle is dropped.
    if (redirect && (state_q != S_HALT)) begin
      pc_d    = redirect_pc & ~PC_WIDTH'(3);
      instr_d = instr_q;
      state_d = S_REQ;
    end
  end

  assign mem_rd      = (state_q == S_REQ);
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign pc          = pc_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (read latency 1 and 3) each driven by a
// fixed-latency instruction memory model.
module tb_fetch_unit;
  localparam int PW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n[2];
  logic          rdy[2];
  logic          redir[2];
  logic [PW-1:0] rpc[2];
  logic [PW-1:0] maddr[2];
  logic          mrd[2];
  logic [31:0]   mrdata[2];
  logic [31:0]   instr[2];
  logic          ivalid[2];
  logic [PW-1:0] pc[2];
  logic          halted[2];
  logic [31:0]   fcnt[2];
  logic [2:0]    st[2];

  logic [31:0]   mem[2][0:255];
  logic          pipe_v[2][3];
  logic [PW-1:0] pipe_a[2][3];
  logic [31:0]   noise[2];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.PC_WIDTH(PW), .RESET_PC('0), .MEM_LATENCY(1)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .mem_addr(maddr[0]), .mem_rd(mrd[0]),
    .mem_rdata(mrdata[0]), .instr(instr[0]), .instr_valid(ivalid[0]),
    .instr_ready(rdy[0]), .pc(pc[0]), .redirect(redir[0]), .redirect_pc(rpc[0]),
    .halted(halted[0]), .fetch_count(fcnt[0]), .state_dbg(st[0])
  );

  fetch_unit #(.PC_WIDTH(PW), .RESET_PC('0), .MEM_LATENCY(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .mem_addr(maddr[1]), .mem_rd(mrd[1]),
    .mem_rdata(mrdata[1]), .instr(instr[1]), .instr_valid(ivalid[1]),
    .instr_ready(rdy[1]), .pc(pc[1]), .redirect(redir[1]), .redirect_pc(rpc[1]),
    .halted(halted[1]), .fetch_count(fcnt[1]), .state_dbg(st[1])
  );

  // Memory model: a read issued in cycle c returns its word in cycle c+LAT;
  // every other cycle carries random nonzero junk.
  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe_v[k][0] <= mrd[k];
      pipe_a[k][0] <= maddr[k];
      for (int i = 1; i < 3; i++) begin
        pipe_v[k][i] <= pipe_v[k][i-1];
        pipe_a[k][i] <= pipe_a[k][i-1];
      end
      noise[k] <= $urandom | 32'h1;
    end
  end

  always @* begin
    for (int k = 0; k < 2; k++) begin
      int d;
      d = lat_of(k) - 1;
      mrdata[k] = pipe_v[k][d] ? mem[k][pipe_a[k][d][9:2]] : noise[k];
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic r, input logic rd, input logic [63:0] p);
    rdy[k]   = r;
    redir[k] = rd;
    rpc[k]   = p;
  endtask

  // Leaves the bench at cycle 0 (IDLE, reset released).
  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    drive(k, 1'b0, 1'b0, '0);
    tick();
    tick();
    rst_n[k] = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [63:0] rpc;
    logic        e_rd;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic [31:0] e_cnt;
    logic        e_halt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [63:0] p,
                              input logic erd, input logic [63:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [63:0] ep,
                              input logic [31:0] ec, input logic eh);
    vec_t v;
    v.rdy = r; v.redir = rd; v.rpc = p; v.e_rd = erd; v.e_addr = ea; v.e_valid = ev;
    v.e_instr = ei; v.e_pc = ep; v.e_cnt = ec; v.e_halt = eh;
    return v;
  endfunction

  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h00A0_0113;
  localparam logic [31:0] W2  = 32'h0020_81B3;
  localparam logic [31:0] W20 = 32'h0010_0213;
  localparam logic [31:0] A0  = 32'h1111_1113;
  localparam logic [31:0] A1  = 32'h2222_2223;
  localparam logic [31:0] A2  = 32'h3333_3333;
  localparam logic [31:0] A40 = 32'h4444_4443;
  localparam logic [31:0] A44 = 32'h5555_5553;

  vec_t tv[22];

  initial begin
    logic [31:0] w;
    logic [63:0] exp_pc;
    int          exp_cnt;
    int          hs;
    logic        found;
    logic        r, rd;
    logic [63:0] p;

    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      drive(k, 1'b0, 1'b0, '0);
      for (int i = 0; i < 256; i++) mem[k][i] = 32'h1000_0000 | 32'(i) | (32'(k) << 20);
    end
    mem[0][0] = W0;  mem[0][1] = W1;  mem[0][2] = W2;  mem[0][3] = 32'h0;
    mem[0][8] = W20; mem[0][9] = 32'h0;
    mem[1][0] = A0;  mem[1][1] = A1;  mem[1][2] = A2;
    mem[1][16] = A40; mem[1][17] = A44;

    //          rdy  rd   rpc    rd   addr   v    instr pc    cnt halt
    tv[0]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  0, 1'b0);
    tv[1]  = mk(1'b1, 1'b0, 64'h0,  1'b1, 64'h0,  1'b0, 32'h0, 64'h0,  0, 1'b0);
    tv[2]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0, 32'h0, 64'h0,  0, 1'b0);
    tv[3]  = mk(1'b1, 1'b0, 64'h0,  1'b0, 64'h0,  1'b1, W0,    64'h0,  0, 1'b0);
    tv[4]  = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'h4,  1'b0, W0,    64'h4,  1, 1'b0);
    tv[5]  = mk(1'b0, 1'b0, 64'h0,  1'b0, 64'h4,  1'b0, W0,    64'h4,  1, 1'b0);
    for (int i = 6; i <= 10; i++)
      tv[i] = mk(1'b0, 1'b0, 64'h0, 1'b0, 64'h4, 1'b1, W1,    64'h4,  1, 1'b0);
    tv[11] = mk(1'b1, 1'b0, 64'h0,  1'b0, 64'h4,  1'b1, W1,    64'h4,  1, 1'b0);
    tv[12] = mk(1'b0, 1'b0, 64'h0,  1'b1, 64'h8,  1'b0, W1,    64'h8,  2, 1'b0);
    tv[13] = mk(1'b0, 1'b0, 64'h0,  1'b0, 64'h8,  1'b0, W1,    64'h8,  2, 1'b0);
    tv[14] = mk(1'b1, 1'b1, 64'h23, 1'b0, 64'h8,  1'b1, W2,    64'h8,  2, 1'b0);
    tv[15] = mk(1'b1, 1'b0, 64'h0,  1'b1, 64'h20, 1'b0, W2,    64'h20, 3, 1'b0);
    tv[16] = mk(1'b1, 1'b0, 64'h0,  1'b0, 64'h20, 1'b0, W2,    64'h20, 3, 1'b0);
    tv[17] = mk(1'b1, 1'b0, 64'h0,  1'b0, 64'h20, 1'b1, W20,   64'h20, 3, 1'b0);
    tv[18] = mk(1'b1, 1'b0, 64'h0,  1'b1, 64'h24, 1'b0, W20,   64'h24, 4, 1'b0);
    tv[19] = mk(1'b1, 1'b0, 64'h0,  1'b0, 64'h24, 1'b0, W20,   64'h24, 4, 1'b0);
    tv[20] = mk(1'b1, 1'b1, 64'h0,  1'b0, 64'h24, 1'b0, W20,   64'h24, 4, 1'b1);
    tv[21] = mk(1'b1, 1'b0, 64'h0,  1'b0, 64'h24, 1'b0, W20,   64'h24, 4, 1'b1);

    // Table: first fetch, backpressure, redirect on a handshake, halt on zero word.
    do_reset(0);
    chk("rst_state", 64'(st[0]), 64'h0);
    for (int c = 0; c < 22; c++) begin
      drive(0, tv[c].rdy, tv[c].redir, tv[c].rpc);
      chk($sformatf("tv%0d_rd", c),    64'(mrd[0]),    64'(tv[c].e_rd));
      chk($sformatf("tv%0d_addr", c),  maddr[0],       tv[c].e_addr);
      chk($sformatf("tv%0d_valid", c), 64'(ivalid[0]), 64'(tv[c].e_valid));
      chk($sformatf("tv%0d_instr", c), 64'(instr[0]),  64'(tv[c].e_instr));
      chk($sformatf("tv%0d_pc", c),    pc[0],          tv[c].e_pc);
      chk($sformatf("tv%0d_cnt", c),   64'(fcnt[0]),   64'(tv[c].e_cnt));
      chk($sformatf("tv%0d_halt", c),  64'(halted[0]), 64'(tv[c].e_halt));
      tick();
    end

    // Straight-line run halting on the zero word at 0xC.
    do_reset(0);
    exp_q.push_back(W0); exp_q.push_back(W1); exp_q.push_back(W2);
    exp_pc = '0;
    found  = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      drive(0, 1'b1, 1'b0, '0);
      if (ivalid[0]) begin
        chk("halt_q_nonempty", 64'(exp_q.size() != 0), 64'h1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("halt_instr", 64'(instr[0]), 64'(w));
          chk("halt_pc", pc[0], exp_pc);
          exp_pc = exp_pc + 64'h4;
        end
      end
      if (halted[0]) found = 1'b1;
      else tick();
    end
    chk("halt_reached", 64'(found), 64'h1);
    chk("halt_drained", 64'(exp_q.size()), 64'h0);
    chk("halt_cnt", 64'(fcnt[0]), 64'h3);
    for (int c = 0; c < 5; c++) begin
      drive(0, 1'b1, 1'b1, '0);
      tick();
      chk("halt_stay", 64'(halted[0]), 64'h1);
      chk("halt_no_rd", 64'(mrd[0]), 64'h0);
      chk("halt_no_valid", 64'(ivalid[0]), 64'h0);
      chk("halt_cnt_hold", 64'(fcnt[0]), 64'h3);
    end

    // Redirect during WAIT with latency 3.
    do_reset(1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      drive(1, 1'b1, 1'b0, '0);
      if (mrd[1] && maddr[1] == 64'h8) found = 1'b1;
      else tick();
    end
    chk("rw_req8_seen", 64'(found), 64'h1);
    tick();
    drive(1, 1'b1, 1'b1, 64'h40);
    tick();
    drive(1, 1'b1, 1'b0, '0);
    chk("rw_req_rd", 64'(mrd[1]), 64'h1);
    chk("rw_req_addr", maddr[1], 64'h40);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      if (ivalid[1]) found = 1'b1;
      else tick();
    end
    chk("rw_valid_seen", 64'(found), 64'h1);
    chk("rw_instr", 64'(instr[1]), 64'(A40));
    chk("rw_pc", pc[1], 64'h40);
    chk("rw_cnt", 64'(fcnt[1]), 64'h2);

    // Reset in the middle of WAIT, then a clean restart.
    tick();
    chk("rm_req_addr", maddr[1], 64'h44);
    tick();
    chk("rm_in_wait_rd", 64'(mrd[1]), 64'h0);
    rst_n[1] = 1'b0;
    drive(1, 1'b0, 1'b0, '0);
    tick();
    chk("rm_rd", 64'(mrd[1]), 64'h0);
    chk("rm_addr", maddr[1], 64'h0);
    chk("rm_valid", 64'(ivalid[1]), 64'h0);
    chk("rm_instr", 64'(instr[1]), 64'h0);
    chk("rm_pc", pc[1], 64'h0);
    chk("rm_halt", 64'(halted[1]), 64'h0);
    chk("rm_cnt", 64'(fcnt[1]), 64'h0);
    chk("rm_state", 64'(st[1]), 64'h0);
    rst_n[1] = 1'b1;
    drive(1, 1'b1, 1'b0, '0);
    tick();
    chk("rm_c1_rd", 64'(mrd[1]), 64'h1);
    chk("rm_c1_addr", maddr[1], 64'h0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("rm_wait_valid", 64'(ivalid[1]), 64'h0);
    end
    tick();
    chk("rm_c5_valid", 64'(ivalid[1]), 64'h1);
    chk("rm_c5_instr", 64'(instr[1]), 64'(A0));
    chk("rm_c5_pc", pc[1], 64'h0);

    // Random ready/redirect against a transaction-level model of the PC stream.
    for (int i = 0; i < 256; i++) mem[0][i] = $urandom | 32'h1;
    do_reset(0);
    exp_pc  = '0;
    exp_cnt = 0;
    hs      = 0;
    for (int c = 0; c < 1500; c++) begin
      r  = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 15) == 0);
      p  = 64'($urandom_range(0, 1023));
      drive(0, r, rd, p);
      if (mrd[0]) chk("rnd_addr", maddr[0], exp_pc);
      if (ivalid[0] && r) begin
        chk("rnd_pc", pc[0], exp_pc);
        chk("rnd_instr", 64'(instr[0]), 64'(mem[0][exp_pc[9:2]]));
        exp_cnt++;
        hs++;
      end
      if (rd) exp_pc = p & ~64'h3;
      else if (ivalid[0] && r) exp_pc = exp_pc + 64'h4;
      tick();
    end
    chk("rnd_cnt", 64'(fcnt[0]), 64'(exp_cnt));
    chk("rnd_no_halt", 64'(halted[0]), 64'h0);
    chk("rnd_progress", 64'(hs > 50), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
